// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector. The flag is a registered Moore pulse one cycle after the completing bit.
// There is no backpressure: din is consumed on every din_valid. Optional cfg_mask port is enabled by SEQDET_MASK_EN.
module seq_detector_param #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
`ifdef SEQDET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               flag,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, DETECT} state_t;

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] hist, hist_nxt;
    logic [LEN_W-1:0]   fill, fill_nxt, fill_inc;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] msk;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] shifted;
    logic               match;
    logic               hit;
    logic               len_ok;

`ifdef SEQDET_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            msk <= '1;
        else if (cfg_load)
            msk <= cfg_mask;
    end
`else
    assign msk = '1;
`endif

    assign len_ok  = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    assign shifted = {hist[MAX_LEN-2:0], din};
    assign armed   = (state == DETECT);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (i < int'(len));
    end

    // Only positions below len (and enabled by the mask) take part in the compare.
    assign match = (((shifted ^ pat) & len_mask & msk) == '0);

    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill;
        fill_inc  = fill + LEN_W'(1);
        hit       = 1'b0;
        if (cfg_load) begin
            state_nxt = len_ok ? FILL : IDLE;
            hist_nxt  = '0;
            fill_nxt  = '0;
        end else if (din_valid) begin
            case (state)
                FILL: begin
                    hist_nxt = shifted;
                    fill_nxt = fill_inc;
                    if (fill_inc == len) begin
                        hit = match;
                        if (match && !ovl)
                            fill_nxt = '0;
                        else
                            state_nxt = DETECT;
                    end
                end
                DETECT: begin
                    hist_nxt = shifted;
                    hit      = match;
                    // Non-overlapping: restart the fill so the next match needs len fresh bits.
                    if (match && !ovl) begin
                        state_nxt = FILL;
                        fill_nxt  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hist  <= '0;
            fill  <= '0;
            pat   <= '0;
            len   <= '0;
            ovl   <= 1'b0;
            flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            hist  <= hist_nxt;
            fill  <= fill_nxt;
            flag  <= hit;
            if (cfg_load) begin
                pat <= cfg_pattern;
                len <= cfg_len;
                ovl <= cfg_overlap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_cnt <= '0;
        else if (cnt_clr)
            match_cnt <= '0;
        else if (hit && (match_cnt != {CNT_W{1'b1}}))
            match_cnt <= match_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a vector table plus hand-written multi-cycle sequences.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din, din_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
`ifdef SEQDET_MASK_EN
    logic [7:0] cfg_mask;
`endif
    logic       flag, armed, flag2, armed2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
`ifdef SEQDET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .flag(flag), .armed(armed), .match_cnt(match_cnt)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
`ifdef SEQDET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .flag(flag2), .armed(armed2), .match_cnt(match_cnt2)
    );

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       clr;
        logic       vld;
        logic       d;
        logic       ef;
        logic       ea;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic [7:0] pat, logic [3:0] len, logic ovl, logic clr,
                                logic vld, logic d, logic ef, logic ea, logic [7:0] ec);
        vec_t v;
        v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.clr = clr;
        v.vld = vld; v.d = d; v.ef = ef; v.ea = ea; v.ec = ec;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        cnt_clr   = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic load(logic [7:0] p, logic [3:0] l, logic o);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step();
    endtask

    task automatic bit_in(logic d);
        din = d; din_valid = 1'b1;
        step();
    endtask

    // Bits of 7'b0101010 in arrival order (first bit is pattern[6]).
    logic [6:0] seq_a;

    initial begin
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0;
        cnt_clr = 1'b0; cfg_pattern = '0; cfg_len = '0;
`ifdef SEQDET_MASK_EN
        cfg_mask = 8'hFF;
`endif
        seq_a = 7'b0101010;
        #12;
        chk("reset_flag", flag, 0);
        chk("reset_armed", armed, 0);
        chk("reset_cnt", match_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ld pat len ovl clr vld d | flag armed cnt
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0));   // IDLE ignores din
        tbl.push_back(mk(1, 8'h2A, 7, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 6; i >= 1; i--)
            tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, seq_a[i], 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 1, 1, 1));   // 7th bit: match
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 1, 1, 2));   // overlapped 9th bit
        tbl.push_back(mk(1, 8'h2A, 7, 0, 0, 0, 0, 0, 0, 2));   // non-overlap
        for (int i = 6; i >= 1; i--)
            tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, seq_a[i], 0, 0, 2));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 0, 0, 3));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 3));   // 9th bit: no flag
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, ~i[0], 0, 0, 3));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 0, 1, 3));   // 7 fresh bits, no match
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 4));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 8'h03, 1, 1, 0, 0, 0, 0, 0, 4));   // illegal len 1
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 0, 0, 4));
        tbl.push_back(mk(1, 8'h00, 9, 1, 0, 0, 0, 0, 0, 4));   // illegal len 9
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 4));
        tbl.push_back(mk(1, 8'h02, 2, 1, 0, 0, 0, 0, 0, 4));   // min len, overlap latched
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 5));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 1, 5));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 6));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 6));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0));   // cnt_clr

        foreach (tbl[k]) begin
            cfg_load = tbl[k].ld; cfg_pattern = tbl[k].pat; cfg_len = tbl[k].len;
            cfg_overlap = tbl[k].ovl; cnt_clr = tbl[k].clr; din_valid = tbl[k].vld; din = tbl[k].d;
            step();
            chk($sformatf("tbl%0d_flag", k), flag, tbl[k].ef);
            chk($sformatf("tbl%0d_armed", k), armed, tbl[k].ea);
            chk($sformatf("tbl%0d_cnt", k), match_cnt, tbl[k].ec);
        end

        // Gaps of 3 invalid cycles between bits.
        load(8'h2A, 7, 1);
        for (int i = 6; i >= 0; i--) begin
            bit_in(seq_a[i]);
            chk($sformatf("gap_bit%0d_flag", i), flag, (i == 0));
            for (int g = 0; g < 3; g++) begin
                step();
                chk($sformatf("gap_bit%0d_idle%0d_flag", i, g), flag, 0);
            end
        end
        chk("gap_cnt", match_cnt, 1);

        // Saturation on the 2-bit counter, then clear against a match.
        cnt_clr = 1'b1; step();
        chk("sat_clr", match_cnt2, 0);
        load(8'h0F, 4, 1);
        for (int i = 0; i < 10; i++) begin
            bit_in(1'b1);
            chk($sformatf("sat%0d_flag", i), flag2, (i >= 3));
            chk($sformatf("sat%0d_armed", i), armed2, (i >= 3));
            chk($sformatf("sat%0d_cnt", i), match_cnt2, (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
        end
        cnt_clr = 1'b1;
        bit_in(1'b1);
        chk("clr_vs_match_flag", flag2, 1);
        chk("clr_vs_match_cnt", match_cnt2, 0);

        // Load with a valid bit mid-fill discards the bit and restarts.
        cnt_clr = 1'b1; step();
        load(8'h2A, 7, 1);
        bit_in(0); bit_in(1); bit_in(0);
        cfg_load = 1'b1; din_valid = 1'b1; din = 1'b1;
        step();
        for (int i = 6; i >= 1; i--) bit_in(seq_a[i]);
        chk("reload_6_flag", flag, 0);
        chk("reload_6_armed", armed, 0);
        bit_in(0);
        chk("reload_7_flag", flag, 1);
        chk("reload_7_armed", armed, 1);
        chk("reload_7_cnt", match_cnt, 1);

        // Async reset mid-DETECT, then the stream is ignored until reload.
        rst_n = 1'b0;
        #2;
        chk("arst_flag", flag, 0);
        chk("arst_armed", armed, 0);
        chk("arst_cnt", match_cnt, 0);
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 6; i >= 0; i--) begin
            bit_in(seq_a[i]);
            chk($sformatf("post_rst%0d_flag", i), flag, 0);
            chk($sformatf("post_rst%0d_armed", i), armed, 0);
        end
        load(8'h2A, 7, 1);
        for (int i = 6; i >= 0; i--) bit_in(seq_a[i]);
        chk("post_rst_reload_flag", flag, 1);

`ifdef SEQDET_MASK_EN
        cnt_clr = 1'b1; step();
        cfg_mask = 8'h77;
        load(8'h2A, 7, 0);
        cfg_mask = 8'hFF;
        for (int i = 6; i >= 0; i--) bit_in(seq_a[i]);
        chk("mask_a_flag", flag, 1);
        seq_a = 7'b0100010;
        for (int i = 6; i >= 0; i--) bit_in(seq_a[i]);
        chk("mask_b_flag", flag, 1);
        chk("mask_cnt", match_cnt, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
